// File: rtl/hazard_pkg.sv
// Shared codes, md timer state type and helpers for the hazard_ctrl_mc controller.
// HAZARD_PERF_CNT_EN enables the stall performance counters in the top.
package hazard_pkg;

  localparam logic [2:0] PCSRC_JR   = 3'b010;
  localparam logic [2:0] PCSRC_EXC  = 3'b011;
  localparam logic [2:0] PCSRC_ERET = 3'b100;

  localparam logic [1:0] FWD_EX_MEM = 2'b01;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Exception entry and eret own the PC redirect, so they never flush on a branch/jump.
  function automatic logic is_exc_src(input logic [2:0] src);
    return (src == PCSRC_EXC) || (src == PCSRC_ERET);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic en);
    return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX/MEM sideband in, stage enables and flushes out.
interface hazard_ctrl_mc_if #(
  parameter int RA_W = 5
);

  logic [2:0]      pc_src;
  logic            branch_hazard;
  logic            jump_hazard;
  logic            id_ex_mem_read;
  logic [RA_W-1:0] id_ex_rt;
  logic            ex_mem_mem_read;
  logic [RA_W-1:0] if_id_rs;
  logic [RA_W-1:0] if_id_rt;
  logic            if_id_uses_rt;
  logic [1:0]      id_fwd_1;
  logic            md_start;
  logic            if_id_uses_hilo;
  logic            dmem_req;
  logic            dmem_ready;

  logic            pc_wen;
  logic            if_wen;
  logic            id_wen;
  logic            ex_wen;
  logic            if_flush;
  logic            id_flush;
  logic            load_use_hazard;
  logic            md_busy;

  modport master (
    output pc_src, branch_hazard, jump_hazard, id_ex_mem_read, id_ex_rt,
           ex_mem_mem_read, if_id_rs, if_id_rt, if_id_uses_rt, id_fwd_1,
           md_start, if_id_uses_hilo, dmem_req, dmem_ready,
    input  pc_wen, if_wen, id_wen, ex_wen, if_flush, id_flush,
           load_use_hazard, md_busy
  );

  modport slave (
    input  pc_src, branch_hazard, jump_hazard, id_ex_mem_read, id_ex_rt,
           ex_mem_mem_read, if_id_rs, if_id_rt, if_id_uses_rt, id_fwd_1,
           md_start, if_id_uses_hilo, dmem_req, dmem_ready,
    output pc_wen, if_wen, id_wen, ex_wen, if_flush, id_flush,
           load_use_hazard, md_busy
  );

endinterface

// File: rtl/md_busy_timer.sv
// Mul/div busy timer: counts MD_LAT cycles after md_start, frozen while data memory stalls.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_i,
  input  logic mem_wait_i,
  output logic md_busy_o
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MD_LAT);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;

  // A frozen pipeline holds EX, so md_start seen during mem_wait is re-issued later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else if (!mem_wait_i) begin
      case (state_q)
        MD_IDLE: begin
          if (md_start_i) begin
            cnt_q   <= LAT;
            state_q <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (md_start_i) begin
            cnt_q <= LAT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_q <= MD_IDLE;
          end
        end
        default: begin
          state_q <= MD_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign md_busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage MIPS core: load-use/jr, HI/LO busy, dmem wait, flushes.
// Define HAZARD_PERF_CNT_EN to add saturating stall-cycle performance counters.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  hazard_ctrl_mc_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         perf_lu_cnt_o,
  output logic [31:0]         perf_md_cnt_o,
  output logic [31:0]         perf_mem_cnt_o
`endif
);

  localparam logic [RA_W-1:0] REG_ZERO = '0;

  logic mem_wait;
  logic rs_hit;
  logic rt_hit;
  logic jr_hit;
  logic load_use;
  logic md_busy;
  logic md_stall;
  logic redirect;

  // Register 0 is hardwired, so a compare against it can never be a real dependency.
  assign mem_wait = hz.dmem_req & ~hz.dmem_ready;
  assign rs_hit   = (hz.id_ex_rt == hz.if_id_rs) && (hz.if_id_rs != REG_ZERO);
  assign rt_hit   = hz.if_id_uses_rt && (hz.id_ex_rt == hz.if_id_rt) && (hz.if_id_rt != REG_ZERO);
  assign jr_hit   = (hz.pc_src == PCSRC_JR) && (hz.id_fwd_1 == FWD_EX_MEM) && hz.ex_mem_mem_read;
  assign load_use = (hz.id_ex_mem_read && (rs_hit || rt_hit)) || jr_hit;
  assign md_stall = md_busy & hz.if_id_uses_hilo;
  assign redirect = (hz.branch_hazard | hz.jump_hazard) & ~is_exc_src(hz.pc_src);

  md_busy_timer #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_md_timer (
    .clk        (clk),
    .reset      (reset),
    .md_start_i (hz.md_start),
    .mem_wait_i (mem_wait),
    .md_busy_o  (md_busy)
  );

  assign hz.md_busy = md_busy;

  // A suppressed branch/jump is not lost: ID re-presents it once the stall clears.
  always_comb begin
    hz.pc_wen          = 1'b1;
    hz.if_wen          = 1'b1;
    hz.id_wen          = 1'b1;
    hz.ex_wen          = 1'b1;
    hz.if_flush        = 1'b0;
    hz.id_flush        = 1'b0;
    hz.load_use_hazard = 1'b0;
    if (!reset) begin
      hz.pc_wen = 1'b1;
    end else if (mem_wait) begin
      hz.pc_wen = 1'b0;
      hz.if_wen = 1'b0;
      hz.id_wen = 1'b0;
      hz.ex_wen = 1'b0;
    end else if (load_use || md_stall) begin
      hz.pc_wen          = 1'b0;
      hz.if_wen          = 1'b0;
      hz.id_flush        = 1'b1;
      hz.load_use_hazard = load_use;
    end else begin
      hz.if_flush = redirect;
      hz.id_flush = hz.branch_hazard;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_q,  perf_lu_d;
  logic [31:0] perf_md_q,  perf_md_d;
  logic [31:0] perf_mem_q, perf_mem_d;

  assign perf_lu_d  = sat_inc32(perf_lu_q,  load_use);
  assign perf_md_d  = sat_inc32(perf_md_q,  md_stall);
  assign perf_mem_d = sat_inc32(perf_mem_q, mem_wait);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_lu_q  <= '0;
      perf_md_q  <= '0;
      perf_mem_q <= '0;
    end else begin
      perf_lu_q  <= perf_lu_d;
      perf_md_q  <= perf_md_d;
      perf_mem_q <= perf_mem_d;
    end
  end

  assign perf_lu_cnt_o  = perf_lu_q;
  assign perf_md_cnt_o  = perf_md_q;
  assign perf_mem_cnt_o = perf_mem_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboarded bench for hazard_ctrl_mc: directed hazard cases then random traffic vs a reference model.
module tb_hazard_ctrl_mc;

  localparam int RA_W   = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;

  typedef struct {
    logic            rstN;
    logic [2:0]      pcSrc;
    logic            branch;
    logic            jump;
    logic            exRead;
    logic [RA_W-1:0] exRt;
    logic            memRead;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic            usesRt;
    logic [1:0]      fwd;
    logic            mdStart;
    logic            usesHilo;
    logic            dmemReq;
    logic            dmemReady;
  } stim_t;

  typedef struct {
    logic pcWen;
    logic ifWen;
    logic idWen;
    logic exWen;
    logic ifFlush;
    logic idFlush;
    logic luHaz;
    logic busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu;
    logic [31:0] md;
    logic [31:0] mem;
`endif
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_mc_if #(.RA_W(RA_W)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perfLu, perfMd, perfMem;
`endif

  hazard_ctrl_mc #(
    .RA_W   (RA_W),
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_lu_cnt_o  (perfLu),
    .perf_md_cnt_o  (perfMd),
    .perf_mem_cnt_o (perfMem)
`endif
  );

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   mdLeft = 0;
  longint mLu = 0, mMd = 0, mMem = 0;

  function automatic stim_t idleStim();
    stim_t s;
    s = '{rstN: 1'b1, pcSrc: 3'd0, branch: 1'b0, jump: 1'b0, exRead: 1'b0, exRt: '0,
          memRead: 1'b0, rs: '0, rt: '0, usesRt: 1'b0, fwd: 2'd0, mdStart: 1'b0,
          usesHilo: 1'b0, dmemReq: 1'b0, dmemReady: 1'b0};
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rstN      = ($urandom_range(0, 99) != 0);
    s.pcSrc     = 3'($urandom_range(0, 4));
    s.branch    = ($urandom_range(0, 3) == 0);
    s.jump      = ($urandom_range(0, 5) == 0);
    s.exRead    = ($urandom_range(0, 2) == 0);
    s.exRt      = RA_W'($urandom_range(0, 3));
    s.memRead   = ($urandom_range(0, 1) == 0);
    s.rs        = RA_W'($urandom_range(0, 3));
    s.rt        = RA_W'($urandom_range(0, 3));
    s.usesRt    = ($urandom_range(0, 1) == 0);
    s.fwd       = 2'($urandom_range(0, 3));
    s.mdStart   = ($urandom_range(0, 5) == 0);
    s.usesHilo  = ($urandom_range(0, 1) == 0);
    s.dmemReq   = ($urandom_range(0, 3) == 0);
    s.dmemReady = ($urandom_range(0, 1) == 0);
    return s;
  endfunction

  // Drive one cycle of inputs, predict the outputs from the hazard rules, then advance the model past the edge.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    logic memWait, loadUse, mdStall, busy;
    @(posedge clk);
    #1;
    reset               = s.rstN;
    bus.pc_src          = s.pcSrc;
    bus.branch_hazard   = s.branch;
    bus.jump_hazard     = s.jump;
    bus.id_ex_mem_read  = s.exRead;
    bus.id_ex_rt        = s.exRt;
    bus.ex_mem_mem_read = s.memRead;
    bus.if_id_rs        = s.rs;
    bus.if_id_rt        = s.rt;
    bus.if_id_uses_rt   = s.usesRt;
    bus.id_fwd_1        = s.fwd;
    bus.md_start        = s.mdStart;
    bus.if_id_uses_hilo = s.usesHilo;
    bus.dmem_req        = s.dmemReq;
    bus.dmem_ready      = s.dmemReady;

    if (!s.rstN) begin
      mdLeft = 0;
      mLu = 0; mMd = 0; mMem = 0;
    end
    busy    = (mdLeft > 0);
    memWait = s.dmemReq && !s.dmemReady;
    loadUse = (s.exRead && ((s.rs != 0 && s.exRt == s.rs) || (s.usesRt && s.rt != 0 && s.exRt == s.rt)))
              || (s.pcSrc == 3'd2 && s.fwd == 2'd1 && s.memRead);
    mdStall = busy && s.usesHilo;

    e.pcWen = 1'b1; e.ifWen = 1'b1; e.idWen = 1'b1; e.exWen = 1'b1;
    e.ifFlush = 1'b0; e.idFlush = 1'b0; e.luHaz = 1'b0;
    e.busy = busy;
    if (s.rstN) begin
      if (memWait) begin
        e.pcWen = 1'b0; e.ifWen = 1'b0; e.idWen = 1'b0; e.exWen = 1'b0;
      end else if (loadUse || mdStall) begin
        e.pcWen = 1'b0; e.ifWen = 1'b0; e.idFlush = 1'b1; e.luHaz = loadUse;
      end else begin
        e.ifFlush = (s.branch || s.jump) && !(s.pcSrc == 3'd3 || s.pcSrc == 3'd4);
        e.idFlush = s.branch;
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    e.lu = 32'(mLu); e.md = 32'(mMd); e.mem = 32'(mMem);
`endif
    expQ.push_back(e);

    if (s.rstN) begin
      if (!memWait) begin
        if (s.mdStart) mdLeft = MD_LAT;
        else if (mdLeft > 0) mdLeft = mdLeft - 1;
      end
      if (loadUse && mLu < 64'hFFFF_FFFF) mLu++;
      if (mdStall && mMd < 64'hFFFF_FFFF) mMd++;
      if (memWait && mMem < 64'hFFFF_FFFF) mMem++;
    end
  endtask

  task automatic cmpBit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, act, req, $time);
    end
  endtask

  task automatic cmpWord(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmpBit("pc_wen",          bus.pc_wen,          e.pcWen);
    cmpBit("if_wen",          bus.if_wen,          e.ifWen);
    cmpBit("id_wen",          bus.id_wen,          e.idWen);
    cmpBit("ex_wen",          bus.ex_wen,          e.exWen);
    cmpBit("if_flush",        bus.if_flush,        e.ifFlush);
    cmpBit("id_flush",        bus.id_flush,        e.idFlush);
    cmpBit("load_use_hazard", bus.load_use_hazard, e.luHaz);
    cmpBit("md_busy",         bus.md_busy,         e.busy);
`ifdef HAZARD_PERF_CNT_EN
    cmpWord("perf_lu_cnt",  perfLu,  e.lu);
    cmpWord("perf_md_cnt",  perfMd,  e.md);
    cmpWord("perf_mem_cnt", perfMem, e.mem);
`else
    if (0) cmpWord("unused", 32'd0, 32'd1);
`endif
  endtask

  // Monitor: outputs are combinational, so every stimulus cycle has a response mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b0;
    bus.pc_src = '0; bus.branch_hazard = 0; bus.jump_hazard = 0; bus.id_ex_mem_read = 0;
    bus.id_ex_rt = '0; bus.ex_mem_mem_read = 0; bus.if_id_rs = '0; bus.if_id_rt = '0;
    bus.if_id_uses_rt = 0; bus.id_fwd_1 = '0; bus.md_start = 0; bus.if_id_uses_hilo = 0;
    bus.dmem_req = 0; bus.dmem_ready = 0;

    s = idleStim(); s.rstN = 1'b0;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idleStim());

    // Load-use on rs, then released; register 0 never stalls.
    s = idleStim(); s.exRead = 1; s.exRt = 5; s.rs = 5;
    applyStimulus(s);
    applyStimulus(idleStim());
    s = idleStim(); s.exRead = 1; s.exRt = 0; s.rs = 0; s.rt = 0; s.usesRt = 1;
    applyStimulus(s);
    s = idleStim(); s.exRead = 1; s.exRt = 7; s.rt = 7; s.usesRt = 1;
    applyStimulus(s);
    s.usesRt = 0;
    applyStimulus(s);

    // jr/jalr forwarding from a load in EX/MEM.
    s = idleStim(); s.pcSrc = 3'b010; s.fwd = 2'b01; s.memRead = 1;
    applyStimulus(s);

    // Mul/div: single op, then an op re-issued while busy.
    s = idleStim(); s.mdStart = 1; s.usesHilo = 1;
    applyStimulus(s);
    s.mdStart = 0;
    repeat (5) applyStimulus(s);
    s.mdStart = 1;
    applyStimulus(s);
    s.mdStart = 0;
    applyStimulus(s);
    s.mdStart = 1;
    applyStimulus(s);
    s.mdStart = 0;
    repeat (6) applyStimulus(s);

    // Data memory wait freezes everything, including the md countdown.
    s = idleStim(); s.mdStart = 1; s.usesHilo = 1;
    applyStimulus(s);
    s = idleStim(); s.usesHilo = 1;
    applyStimulus(s);
    s.dmemReq = 1; s.dmemReady = 0;
    repeat (3) applyStimulus(s);
    s.dmemReady = 1;
    repeat (5) applyStimulus(s);

    // Branch/jump flushes, exception suppression, and stall suppression.
    s = idleStim(); s.branch = 1; s.pcSrc = 3'b001;
    applyStimulus(s);
    s = idleStim(); s.jump = 1; s.pcSrc = 3'b011;
    applyStimulus(s);
    s = idleStim(); s.jump = 1; s.pcSrc = 3'b000;
    applyStimulus(s);
    s = idleStim(); s.branch = 1; s.exRead = 1; s.exRt = 3; s.rs = 3;
    applyStimulus(s);

    // Reset asserted while the md timer is busy.
    s = idleStim(); s.mdStart = 1; s.usesHilo = 1;
    applyStimulus(s);
    s.mdStart = 0;
    applyStimulus(s);
    s.rstN = 0;
    applyStimulus(s);
    s.rstN = 1;
    repeat (2) applyStimulus(s);

    for (int i = 0; i < 600; i++) applyStimulus(randStim());

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL drain: %0d responses left, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
Next-generation pipeline hazard controller for the 5-stage MIPS core. It covers the original load-use, jr/jalr-forward and branch/jump flush hazards and adds three things. First, a parametrised register-address width. Second, a multi-cycle mul/div busy timer that stalls HI/LO consumers. Third, a data-memory wait handshake that freezes the whole pipeline. It sits beside the ID stage and drives the PC, IF/ID, ID/EX and EX/MEM write-enables and flushes.

Parameters:
RA_W, 5, register address width
MD_LAT, 4, mul/div result latency in cycles after md_start (legal range 1..15)
CNT_W, 4, width of md busy counter; must satisfy 2^CNT_W > MD_LAT

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
pc_src  in  3  PC source select; 3'b010 = jr/jalr, 3'b011/3'b100 = exception/eret
branch_hazard  in  1  branch taken, resolved in ID
jump_hazard  in  1  jump taken in ID
id_ex_mem_read  in  1  ID/EX holds a load
id_ex_rt  in  RA_W  load destination in ID/EX
ex_mem_mem_read  in  1  EX/MEM holds a load
if_id_rs  in  RA_W  ID source rs
if_id_rt  in  RA_W  ID source rt
if_id_uses_rt  in  1  ID instruction actually reads rt
id_fwd_1  in  2  ID forward select for rs; 2'b01 = from EX/MEM
md_start  in  1  mul/div issued from EX this cycle
if_id_uses_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo/mul/div)
dmem_req  in  1  EX/MEM has a memory access in flight
dmem_ready  in  1  data memory completes the access this cycle
pc_wen  out  1  PC write enable
if_wen  out  1  IF/ID write enable
id_wen  out  1  ID/EX write enable
ex_wen  out  1  EX/MEM write enable
if_flush  out  1  IF/ID flush
id_flush  out  1  ID/EX flush (bubble insert)
load_use_hazard  out  1  load-use (incl. jr) stall this cycle
md_busy  out  1  mul/div result not yet available

Behaviour:
- Reset (reset=0) is asynchronous. While asserted: md counter=0, md_busy=0, all wen=1, all flush=0, load_use_hazard=0.
- Combinational stall terms:
  - mem_wait = dmem_req & ~dmem_ready.
  - load_use = (id_ex_mem_read & (id_ex_rt==if_id_rs | (if_id_uses_rt & id_ex_rt==if_id_rt))) | (pc_src==3'b010 & id_fwd_1==2'b01 & ex_mem_mem_read).
  - md_stall = md_busy & if_id_uses_hilo.
  - Register 0 never causes load-use: an rs/rt compare with 0 is masked.
- Priority and outputs:
  - mem_wait: pc_wen=if_wen=id_wen=ex_wen=0, no flush, load_use_hazard=0.
  - else load_use | md_stall: pc_wen=if_wen=0, id_flush=1 (bubble), id_wen=ex_wen=1, if_flush=0. load_use_hazard=load_use.
  - else if_flush = (branch_hazard|jump_hazard) & pc_src not in {3'b011,3'b100}; id_flush = branch_hazard; all wen=1.
  - A branch/jump seen during a stall is suppressed, not lost: it is re-evaluated when ID re-presents.
- md timer FSM, states IDLE/BUSY:
  - IDLE: md_start loads counter=MD_LAT, goes to BUSY.
  - BUSY: decrement each cycle unless mem_wait (frozen while frozen); at count 1→0 go to IDLE.
  - md_start in BUSY reloads MD_LAT (new op replaces old).
  - md_busy = (state==BUSY), registered, so it is asserted the cycle after md_start.
  - md_start in the same cycle as mem_wait is ignored: EX is held and re-issues it.
- Stall latency is 0 cycles (combinational from inputs). Only the md timer is sequential.
- Reset mid-BUSY returns the FSM to IDLE immediately.

Optional Feature:
HAZARD_PERF_CNT_EN: adds outputs perf_lu_cnt, perf_md_cnt, perf_mem_cnt (32 bits each). These are saturating counts of cycles with load_use, md_stall and mem_wait respectively, cleared by reset. Without the macro these ports and registers do not exist.

Decomposition:
- Shared package hazard_pkg holds: pc_src codes (PCSRC_JR=3'b010, PCSRC_EXC=3'b011, PCSRC_ERET=3'b100), forward code FWD_EX_MEM=2'b01, md FSM state enum.
- One sub-module, md_busy_timer (MD_LAT, CNT_W), holds the md FSM and counter.

Test Plan:
- id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 → pc_wen=if_wen=0, id_flush=1, load_use_hazard=1 for exactly 1 cycle. With if_id_rs=0, id_ex_rt=0 → no stall.
- pc_src=3'b010, id_fwd_1=2'b01, ex_mem_mem_read=1 → load_use_hazard=1.
- md_start pulse, MD_LAT=4, if_id_uses_hilo=1 → md_busy high 4 cycles starting the next cycle, with pc_wen=0 throughout. A second md_start at cycle 2 extends busy to cycle 2+4.
- dmem_req=1, dmem_ready=0 for 3 cycles while BUSY → all wen=0 and md counter held for 3 cycles; resumes on dmem_ready=1.
- branch_hazard=1, pc_src=3'b001 → if_flush=1, id_flush=1. jump_hazard=1, pc_src=3'b011 → if_flush=0. branch_hazard coinciding with load_use → no flush that cycle.
- reset deasserted→asserted during BUSY → md_busy=0 immediately, outputs at reset values.
